btn_input_conditioner: RTL and testbench

//  Front end for the finger-guessing game. Sits between the raw board push-buttons and State_Machine.

---
 rtl/btn_input_conditioner_pkg.sv | 33 +++
 rtl/btn_debounce_ch.sv | 49 ++++
 rtl/btn_input_conditioner.sv | 119 +++++++++++
 tb/tb_btn_input_conditioner.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_input_conditioner_pkg.sv
// Shared constants and helpers for the button front end of the finger-guessing game.
//   GEST_0..GEST_2      : gesture encodings held in Choice_L / Choice_R (2'b11 is never used)
//   *_DEF localparams   : default synchroniser depth, debounce length and counter width
//   gest_index()        : index of the set bit of a one-hot gesture vector
//   multi_hot()         : true when two or more gesture bits are set
package btn_input_conditioner_pkg;

    localparam logic [1:0] GEST_0 = 2'd0;
    localparam logic [1:0] GEST_1 = 2'd1;
    localparam logic [1:0] GEST_2 = 2'd2;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int DEB_CYCLES_DEF  = 1_000_000;  // 20 ms at 50 MHz
    localparam int CNT_W_DEF       = 20;

    // Only meaningful for a one-hot input; the latch never calls it otherwise.
    function automatic logic [1:0] gest_index(input logic [2:0] presses);
        logic [1:0] idx;
        idx = GEST_0;
        casez (presses)
            3'b??1:  idx = GEST_0;
            3'b?10:  idx = GEST_1;
            3'b100:  idx = GEST_2;
            default: idx = GEST_0;
        endcase
        return idx;
    endfunction

    function automatic logic multi_hot(input logic [2:0] presses);
        return (presses[0] & presses[1]) | (presses[0] & presses[2]) | (presses[1] & presses[2]);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, debounce counter, debounced level and rising-edge pulse.
//   clk        : system clock
//   rst_n      : asynchronous reset, active-low
//   btn_raw    : raw button level, asynchronous to clk
//   btn_pulse  : registered 1-cycle pulse on a debounced press (release gives nothing)
module btn_debounce_ch #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int CNT_W       = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   stable;
    logic                   stable_prev;
    logic [CNT_W-1:0]       cnt;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            stable      <= 1'b0;
            stable_prev <= 1'b0;
            cnt         <= '0;
            btn_pulse   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], btn_raw};
            stable_prev <= stable;
            btn_pulse   <= stable & ~stable_prev;
            // Any cycle where the synced level agrees with the accepted level
            // restarts the count, so a bounce shorter than DEB_CYCLES is dropped.
            if (synced == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                stable <= synced;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_input_conditioner.sv
// Front end between the raw game buttons and State_Machine. Every button is
// synchronised, debounced and edge-detected; each player's first clean gesture
// is latched until State_Machine pulses Choice_Clr.
//   Sys_Clk, Sys_Rst            : clock, asynchronous active-low reset
//   BTN_Ready, BTN_Go           : raw control buttons
//   BTN_Player_L/R [2:0]        : raw gesture buttons, bit i = gesture i
//   Choice_Clr                  : clears both latched choices (wins over same-cycle presses)
//   Ready_Pulse, Go_Pulse       : 1-cycle debounced press pulses
//   Pla_L/R_Pulse [2:0]         : per-gesture 1-cycle press pulses, always forwarded
//   Choice_L/R [1:0], Choice_Vld_L/R : latched gesture and its valid flag
//   Multi_Err_L/R               : 1-cycle pulse when an unlatched player presses >=2 gestures at once
module btn_input_conditioner
    import btn_input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       Sys_Clk,
    input  logic       Sys_Rst,
    input  logic       BTN_Ready,
    input  logic       BTN_Go,
    input  logic [2:0] BTN_Player_L,
    input  logic [2:0] BTN_Player_R,
    input  logic       Choice_Clr,
    output logic       Ready_Pulse,
    output logic       Go_Pulse,
    output logic [2:0] Pla_L_Pulse,
    output logic [2:0] Pla_R_Pulse,
    output logic [1:0] Choice_L,
    output logic [1:0] Choice_R,
    output logic       Choice_Vld_L,
    output logic       Choice_Vld_R,
    output logic       Multi_Err_L,
    output logic       Multi_Err_R
);

    // Channel order: {R[2:0], L[2:0], Go, Ready}
    logic [7:0] raw;
    logic [7:0] pulses;

    assign raw = {BTN_Player_R, BTN_Player_L, BTN_Go, BTN_Ready};

    for (genvar i = 0; i < 8; i++) begin : g_ch
        btn_debounce_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk       (Sys_Clk),
            .rst_n     (Sys_Rst),
            .btn_raw   (raw[i]),
            .btn_pulse (pulses[i])
        );
    end

    assign Ready_Pulse = pulses[0];
    assign Go_Pulse    = pulses[1];
    assign Pla_L_Pulse = pulses[4:2];
    assign Pla_R_Pulse = pulses[7:5];

    logic [1:0] choice_l_d, choice_r_d;
    logic       vld_l_d, vld_r_d;
    logic       err_l_d, err_r_d;

    // Latch priority per player: clear, then hold, then single press, then multi-press error.
    always_comb begin
        choice_l_d = Choice_L;
        vld_l_d    = Choice_Vld_L;
        err_l_d    = 1'b0;
        if (Choice_Clr) begin
            choice_l_d = GEST_0;
            vld_l_d    = 1'b0;
        end else if (!Choice_Vld_L) begin
            if (multi_hot(Pla_L_Pulse)) begin
                err_l_d = 1'b1;
            end else if (|Pla_L_Pulse) begin
                choice_l_d = gest_index(Pla_L_Pulse);
                vld_l_d    = 1'b1;
            end
        end
    end

    always_comb begin
        choice_r_d = Choice_R;
        vld_r_d    = Choice_Vld_R;
        err_r_d    = 1'b0;
        if (Choice_Clr) begin
            choice_r_d = GEST_0;
            vld_r_d    = 1'b0;
        end else if (!Choice_Vld_R) begin
            if (multi_hot(Pla_R_Pulse)) begin
                err_r_d = 1'b1;
            end else if (|Pla_R_Pulse) begin
                choice_r_d = gest_index(Pla_R_Pulse);
                vld_r_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge Sys_Clk or negedge Sys_Rst) begin
        if (!Sys_Rst) begin
            Choice_L     <= GEST_0;
            Choice_R     <= GEST_0;
            Choice_Vld_L <= 1'b0;
            Choice_Vld_R <= 1'b0;
            Multi_Err_L  <= 1'b0;
            Multi_Err_R  <= 1'b0;
        end else begin
            Choice_L     <= choice_l_d;
            Choice_R     <= choice_r_d;
            Choice_Vld_L <= vld_l_d;
            Choice_Vld_R <= vld_r_d;
            Multi_Err_L  <= err_l_d;
            Multi_Err_R  <= err_r_d;
        end
    end

endmodule

// File: tb/tb_btn_input_conditioner.sv
module tb_btn_input_conditioner;

    localparam int DEB  = 4;
    localparam int LAT  = 7;  // drive at negedge c -> pulse seen at negedge c+7

    // Event kinds used in the expected-pulse queue
    localparam int K_READY = 0;
    localparam int K_GO    = 1;
    localparam int K_L     = 2;
    localparam int K_R     = 3;
    localparam int K_ERR_L = 4;
    localparam int K_ERR_R = 5;

    logic       Sys_Clk = 1'b0;
    logic       Sys_Rst = 1'b1;
    logic       BTN_Ready = 1'b0;
    logic       BTN_Go = 1'b0;
    logic [2:0] BTN_Player_L = 3'b000;
    logic [2:0] BTN_Player_R = 3'b000;
    logic       Choice_Clr = 1'b0;
    logic       Ready_Pulse, Go_Pulse;
    logic [2:0] Pla_L_Pulse, Pla_R_Pulse;
    logic [1:0] Choice_L, Choice_R;
    logic       Choice_Vld_L, Choice_Vld_R;
    logic       Multi_Err_L, Multi_Err_R;

    btn_input_conditioner #(
        .SYNC_STAGES (2),
        .DEB_CYCLES  (DEB),
        .CNT_W       (20)
    ) dut (
        .Sys_Clk      (Sys_Clk),
        .Sys_Rst      (Sys_Rst),
        .BTN_Ready    (BTN_Ready),
        .BTN_Go       (BTN_Go),
        .BTN_Player_L (BTN_Player_L),
        .BTN_Player_R (BTN_Player_R),
        .Choice_Clr   (Choice_Clr),
        .Ready_Pulse  (Ready_Pulse),
        .Go_Pulse     (Go_Pulse),
        .Pla_L_Pulse  (Pla_L_Pulse),
        .Pla_R_Pulse  (Pla_R_Pulse),
        .Choice_L     (Choice_L),
        .Choice_R     (Choice_R),
        .Choice_Vld_L (Choice_Vld_L),
        .Choice_Vld_R (Choice_Vld_R),
        .Multi_Err_L  (Multi_Err_L),
        .Multi_Err_R  (Multi_Err_R)
    );

    // ---------------- clock / cycle count ----------------
    always #5 Sys_Clk = ~Sys_Clk;

    int cyc = 0;
    always @(posedge Sys_Clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 1'b0;
    logic [21:0] exp_q[$];
    logic [2:0]  obs[6];
    logic [21:0] got_ev, want_ev;

    function automatic logic [21:0] ev(input int c, input int k, input logic [2:0] v);
        logic [15:0] cc;
        logic [2:0]  kk;
        cc = 16'(c);
        kk = 3'(k);
        return {cc, kk, v};
    endfunction

    // Every pulse output that fires must match the head of the expected queue.
    always @(negedge Sys_Clk) begin
        if (mon_en) begin
            obs[K_READY] = {2'b00, Ready_Pulse};
            obs[K_GO]    = {2'b00, Go_Pulse};
            obs[K_L]     = Pla_L_Pulse;
            obs[K_R]     = Pla_R_Pulse;
            obs[K_ERR_L] = {2'b00, Multi_Err_L};
            obs[K_ERR_R] = {2'b00, Multi_Err_R};
            for (int k = 0; k < 6; k++) begin
                if (obs[k] !== 3'b000) begin
                    checks++;
                    got_ev = ev(cyc, k, obs[k]);
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL pulse_unexpected: got cyc=%0d kind=%0d val=%b, required no pulse",
                                 cyc, k, obs[k]);
                    end else begin
                        want_ev = exp_q.pop_front();
                        if (got_ev !== want_ev) begin
                            errors++;
                            $display("FAIL pulse_event: got cyc=%0d kind=%0d val=%b, required cyc=%0d kind=%0d val=%b",
                                     got_ev[21:6], got_ev[5:3], got_ev[2:0],
                                     want_ev[21:6], want_ev[5:3], want_ev[2:0]);
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_neg(input int n);
        repeat (n) @(negedge Sys_Clk);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge Sys_Clk);
    endtask

    function automatic logic [15:0] all_outs();
        return {Ready_Pulse, Go_Pulse, Pla_L_Pulse, Pla_R_Pulse, Choice_L, Choice_R,
                Choice_Vld_L, Choice_Vld_R, Multi_Err_L, Multi_Err_R};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 Sys_Rst = 1'b0;
        wait_neg(3);
        checks++;
        if (all_outs() !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0000", all_outs());
        end
        Sys_Rst = 1'b1;
        mon_en  = 1'b1;
        wait_neg(2);
    endtask

    task automatic test_go_pulse();
        int c;
        c = cyc;
        BTN_Go = 1'b1;
        exp_q.push_back(ev(c + LAT, K_GO, 3'b001));
        wait_cyc(c + LAT - 1);
        checks++;
        if (Go_Pulse !== 1'b0) begin
            errors++;
            $display("FAIL go_early: got %b, required 0", Go_Pulse);
        end
        wait_cyc(c + LAT);
        checks++;
        if (Go_Pulse !== 1'b1) begin
            errors++;
            $display("FAIL go_high: got %b, required 1", Go_Pulse);
        end
        wait_cyc(c + LAT + 1);
        checks++;
        if (Go_Pulse !== 1'b0) begin
            errors++;
            $display("FAIL go_one_cycle: got %b, required 0", Go_Pulse);
        end
        wait_cyc(c + 20);
        BTN_Go = 1'b0;
        wait_neg(12);
    endtask

    task automatic test_bounce();
        int c;
        for (int i = 0; i < 2; i++) begin
            BTN_Ready = 1'b1;
            wait_neg(2);
            BTN_Ready = 1'b0;
            wait_neg(2);
        end
        c = cyc;
        BTN_Ready = 1'b1;
        exp_q.push_back(ev(c + LAT, K_READY, 3'b001));
        wait_cyc(c + LAT);
        checks++;
        if (Ready_Pulse !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_bounce: got %b, required 1", Ready_Pulse);
        end
        wait_neg(15);
        BTN_Ready = 1'b0;
        wait_neg(12);
    endtask

    task automatic test_choice_latch();
        int c;
        c = cyc;
        BTN_Player_L = 3'b010;
        exp_q.push_back(ev(c + LAT, K_L, 3'b010));
        wait_cyc(c + LAT);
        checks++;
        if (Pla_L_Pulse !== 3'b010) begin
            errors++;
            $display("FAIL pla_l_pulse: got %b, required 010", Pla_L_Pulse);
        end
        wait_cyc(c + LAT + 1);
        checks++;
        if ({Pla_L_Pulse, Choice_Vld_L, Choice_L} !== {3'b000, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL latch_l1: got pulse=%b vld=%b choice=%0d, required pulse=000 vld=1 choice=1",
                     Pla_L_Pulse, Choice_Vld_L, Choice_L);
        end
        wait_cyc(c + 12);
        BTN_Player_L = 3'b000;
        wait_neg(12);

        c = cyc;
        BTN_Player_L = 3'b100;
        exp_q.push_back(ev(c + LAT, K_L, 3'b100));
        wait_cyc(c + LAT + 2);
        checks++;
        if ({Choice_Vld_L, Choice_L} !== {1'b1, 2'd1}) begin
            errors++;
            $display("FAIL latch_hold: got vld=%b choice=%0d, required vld=1 choice=1", Choice_Vld_L, Choice_L);
        end
        BTN_Player_L = 3'b000;
        wait_neg(12);

        Choice_Clr = 1'b1;
        wait_neg(1);
        Choice_Clr = 1'b0;
        checks++;
        if ({Choice_Vld_L, Choice_L} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL latch_clear: got vld=%b choice=%0d, required vld=0 choice=0", Choice_Vld_L, Choice_L);
        end
        wait_neg(2);
    endtask

    task automatic test_multi();
        int c;
        c = cyc;
        BTN_Player_L = 3'b101;
        BTN_Player_R = 3'b100;
        exp_q.push_back(ev(c + LAT, K_L, 3'b101));
        exp_q.push_back(ev(c + LAT, K_R, 3'b100));
        exp_q.push_back(ev(c + LAT + 1, K_ERR_L, 3'b001));
        wait_cyc(c + LAT + 1);
        checks++;
        if ({Multi_Err_L, Choice_Vld_L, Multi_Err_R, Choice_Vld_R, Choice_R} !== {1'b1, 1'b0, 1'b0, 1'b1, 2'd2}) begin
            errors++;
            $display("FAIL multi_err: got errL=%b vldL=%b errR=%b vldR=%b choiceR=%0d, required errL=1 vldL=0 errR=0 vldR=1 choiceR=2",
                     Multi_Err_L, Choice_Vld_L, Multi_Err_R, Choice_Vld_R, Choice_R);
        end
        wait_cyc(c + LAT + 2);
        checks++;
        if ({Multi_Err_L, Choice_Vld_L} !== 2'b00) begin
            errors++;
            $display("FAIL multi_err_one_cycle: got errL=%b vldL=%b, required errL=0 vldL=0", Multi_Err_L, Choice_Vld_L);
        end
        BTN_Player_L = 3'b000;
        BTN_Player_R = 3'b000;
        wait_neg(12);
    endtask

    task automatic test_clr_collision();
        int c;
        Choice_Clr = 1'b1;
        wait_neg(1);
        Choice_Clr = 1'b0;
        checks++;
        if (Choice_Vld_R !== 1'b0) begin
            errors++;
            $display("FAIL clr_r_pre: got vld=%b, required 0", Choice_Vld_R);
        end
        c = cyc;
        BTN_Player_R = 3'b001;
        exp_q.push_back(ev(c + LAT, K_R, 3'b001));
        wait_cyc(c + LAT);
        Choice_Clr = 1'b1;
        checks++;
        if (Pla_R_Pulse !== 3'b001) begin
            errors++;
            $display("FAIL clr_collide_pulse: got %b, required 001", Pla_R_Pulse);
        end
        wait_cyc(c + LAT + 1);
        Choice_Clr = 1'b0;
        checks++;
        if ({Choice_Vld_R, Choice_R, Multi_Err_R} !== {1'b0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL clr_collide: got vld=%b choice=%0d err=%b, required vld=0 choice=0 err=0",
                     Choice_Vld_R, Choice_R, Multi_Err_R);
        end
        wait_cyc(c + LAT + 3);
        checks++;
        if (Choice_Vld_R !== 1'b0) begin
            errors++;
            $display("FAIL clr_collide_later: got vld=%b, required 0", Choice_Vld_R);
        end
        BTN_Player_R = 3'b000;
        wait_neg(12);
    endtask

    task automatic test_reset_mid_count();
        int c;
        c = cyc;
        BTN_Player_R = 3'b010;
        exp_q.push_back(ev(c + LAT, K_R, 3'b010));
        wait_cyc(c + LAT + 1);
        checks++;
        if ({Choice_Vld_R, Choice_R} !== {1'b1, 2'd1}) begin
            errors++;
            $display("FAIL pre_reset_latch: got vld=%b choice=%0d, required vld=1 choice=1", Choice_Vld_R, Choice_R);
        end
        BTN_Player_R = 3'b000;
        wait_neg(12);

        c = cyc;
        BTN_Player_L = 3'b001;
        wait_cyc(c + 4);
        @(posedge Sys_Clk);
        #2 Sys_Rst = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: got %h, required 0000", all_outs());
        end
        wait_neg(2);
        c = cyc;
        Sys_Rst = 1'b1;
        exp_q.push_back(ev(c + LAT, K_L, 3'b001));
        wait_cyc(c + LAT + 1);
        checks++;
        if ({Choice_Vld_L, Choice_L, Choice_Vld_R} !== {1'b1, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_latch: got vldL=%b choiceL=%0d vldR=%b, required vldL=1 choiceL=0 vldR=0",
                     Choice_Vld_L, Choice_L, Choice_Vld_R);
        end
        BTN_Player_L = 3'b000;
        wait_neg(12);
    endtask

    initial begin
        test_reset();
        test_go_pulse();
        test_bounce();
        test_choice_latch();
        test_multi();
        test_clr_collision();
        test_reset_mid_count();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pulses_missing: got %0d expected pulses never seen, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
